// File: rtl/z80_gpio_bank_if.sv
// Z8S180 I/O bus as seen by the GPIO bank: strobes, address and write data in, read data out.
interface z80_gpio_bank_if;
    logic       iorq_n;
    logic       rd_n;
    logic       wr_n;
    logic [7:0] a;
    logic [7:0] din;
    logic [7:0] dout;
    logic       dbus_out;

    modport master (output iorq_n, rd_n, wr_n, a, din, input dout, dbus_out);
    modport slave  (input iorq_n, rd_n, wr_n, a, din, output dout, dbus_out);
endinterface

// File: rtl/z80_gpio_bank.sv
// Multi-bank GPIO for the Z8S180 I/O bus: self-decoded window, phi-timed write strobe, per-pin DIR.
// Define GPIO_IRQ_EN to add the IEN/STAT/EDGE registers, edge detection and the irq output.
module z80_gpio_bank #(
    parameter logic [7:0] BASE_ADDR   = 8'hF0,
    parameter int         BANKS       = 1,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                 phi,
    input  logic                 reset_n,
    z80_gpio_bank_if.slave       bus,
    input  logic [8*BANKS-1:0]   pin_in,
    output logic [8*BANKS-1:0]   pin_out,
    output logic [8*BANKS-1:0]   pin_oe,
    output logic                 irq
);

    localparam int         W        = 8 * BANKS;
    localparam logic [8:0] WIN_SIZE = 9'(W);
    localparam logic [2:0] R_IN     = 3'd0;
    localparam logic [2:0] R_OUT    = 3'd1;
    localparam logic [2:0] R_DIR    = 3'd2;

    typedef enum logic [1:0] {
        WS_IDLE   = 2'd0,
        WS_FIRST  = 2'd1,
        WS_SECOND = 2'd2,
        WS_SAT    = 2'd3
    } wr_cnt_t;

    logic [7:0] offset;
    logic       hit;
    logic [1:0] bank_sel;
    logic [2:0] reg_sel;

    // The window may run past 8'hFF for large BANKS; the lower-bound test stops wrap-around hits.
    assign offset   = bus.a - BASE_ADDR;
    assign hit      = !bus.iorq_n && (bus.a >= BASE_ADDR) && ({1'b0, offset} < WIN_SIZE);
    assign bank_sel = offset[4:3];
    assign reg_sel  = offset[2:0];

    assign bus.dbus_out = hit && !bus.rd_n;

    wr_cnt_t cnt_q;
    logic    wr_act;
    logic    commit;

    assign wr_act = hit && !bus.wr_n;
    // Only the edge leaving WS_FIRST commits, so wait states never cause a second write.
    assign commit = wr_act && (cnt_q == WS_FIRST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge phi or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= WS_IDLE;
        end else if (!wr_act) begin
            cnt_q <= WS_IDLE;
        end else begin
            case (cnt_q)
                WS_IDLE:  cnt_q <= WS_FIRST;
                WS_FIRST: cnt_q <= WS_SECOND;
                default:  cnt_q <= WS_SAT;
            endcase
        end
    end

    logic [SYNC_STAGES-1:0][W-1:0] sync_q;
    logic [W-1:0]                  in_sync;
    logic [BANKS-1:0][7:0]         out_q, out_d;
    logic [BANKS-1:0][7:0]         dir_q, dir_d;

    assign in_sync = sync_q[SYNC_STAGES-1];
    assign pin_out = out_q;
    assign pin_oe  = dir_q;

    // NOTE: next-state logic assigns defaults before any branch, so no latch can be inferred.
    always_comb begin
        out_d = out_q;
        dir_d = dir_q;
        for (int b = 0; b < BANKS; b++) begin
            if (commit && (bank_sel == b[1:0])) begin
                case (reg_sel)
                    R_OUT:   out_d[b] = bus.din;
                    R_DIR:   dir_d[b] = bus.din;
                    default: ;
                endcase
            end
        end
    end

    // NOTE: the per-bank register arrays are reset like any flop so pins come up as inputs.
    always_ff @(posedge phi or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            out_q  <= '0;
            dir_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_in};
            out_q  <= out_d;
            dir_q  <= dir_d;
        end
    end

`ifdef GPIO_IRQ_EN
    localparam logic [2:0] R_IEN    = 3'd3;
    localparam logic [2:0] R_STAT   = 3'd4;
    localparam logic [2:0] R_EDGE   = 3'd5;
    localparam logic [2:0] ARM_DONE = 3'(SYNC_STAGES + 1);

    logic [BANKS-1:0][7:0] ien_q, ien_d;
    logic [BANKS-1:0][7:0] stat_q, stat_d;
    logic [BANKS-1:0][7:0] edge_q, edge_d;
    logic [W-1:0]          prev_q;
    logic [W-1:0]          edge_sel;
    logic [W-1:0]          ev;
    logic [2:0]            arm_q;
    logic                  irq_q;

    // Events stay masked until the synchroniser and prev flop hold real pin values after reset.
    assign edge_sel = edge_q;
    assign ev = (arm_q == ARM_DONE)
              ? ((edge_sel & ~in_sync & prev_q) | (~edge_sel & in_sync & ~prev_q))
              : '0;

    always_comb begin
        ien_d  = ien_q;
        edge_d = edge_q;
        stat_d = stat_q;
        for (int b = 0; b < BANKS; b++) begin
            if (commit && (bank_sel == b[1:0])) begin
                case (reg_sel)
                    R_IEN:   ien_d[b]  = bus.din;
                    R_EDGE:  edge_d[b] = bus.din;
                    R_STAT:  stat_d[b] = stat_q[b] & ~bus.din;
                    default: ;
                endcase
            end
            // Applied after the W1C clear so a coincident new event keeps its bit set.
            stat_d[b] = stat_d[b] | ev[8*b +: 8];
        end
    end

    always_ff @(posedge phi or negedge reset_n) begin
        if (!reset_n) begin
            ien_q  <= '0;
            stat_q <= '0;
            edge_q <= '0;
            prev_q <= '0;
            arm_q  <= '0;
            irq_q  <= 1'b0;
        end else begin
            ien_q  <= ien_d;
            stat_q <= stat_d;
            edge_q <= edge_d;
            prev_q <= in_sync;
            if (arm_q != ARM_DONE) arm_q <= arm_q + 3'd1;
            irq_q  <= |(stat_q & ien_q);
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    logic [7:0] rd_data;

    always_comb begin
        rd_data = '0;
        if (hit) begin
            for (int b = 0; b < BANKS; b++) begin
                if (bank_sel == b[1:0]) begin
                    case (reg_sel)
                        R_IN:    rd_data = in_sync[8*b +: 8];
                        R_OUT:   rd_data = out_q[b];
                        R_DIR:   rd_data = dir_q[b];
`ifdef GPIO_IRQ_EN
                        R_IEN:   rd_data = ien_q[b];
                        R_STAT:  rd_data = stat_q[b];
                        R_EDGE:  rd_data = edge_q[b];
`endif
                        default: rd_data = '0;
                    endcase
                end
            end
        end
    end

    assign bus.dout = rd_data;

endmodule
